// File: rtl/rot_pkg.sv
// Shared codes and helpers for the tile-rotation address engines.
package rot_pkg;

  typedef enum logic [1:0] {DEG_0 = 2'd0, DEG_90 = 2'd1, DEG_180 = 2'd2, DEG_270 = 2'd3} deg_e;
  typedef enum logic {DIR_CW = 1'b0, DIR_CCW = 1'b1} dir_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_e;

  // Fold direction into a clockwise quarter-turn count.
  function automatic logic [1:0] eff_deg(input logic [1:0] deg, input logic dir);
    return (dir_e'(dir) == DIR_CCW) ? 2'(2'd0 - deg) : deg;
  endfunction

endpackage

// File: rtl/rot_coord_map.sv
// Maps an output coordinate to its source coordinate for a clockwise
// rotation followed by an optional horizontal mirror.
module rot_coord_map
  import rot_pkg::*;
#(
  parameter int TILE  = 8,
  parameter int CNT_W = $clog2(TILE)
) (
  input  logic [CNT_W-1:0] r,
  input  logic [CNT_W-1:0] c,
  input  logic [1:0]       deg_cw,
  input  logic             mirror,
  output logic [CNT_W-1:0] src_r,
  output logic [CNT_W-1:0] src_c
);

  logic [CNT_W-1:0] cm;

  // TILE is a power of two, so (TILE-1) - x is just ~x.
  always_comb begin
    cm    = mirror ? ~c : c;
    src_r = r;
    src_c = cm;
    case (deg_e'(deg_cw))
      DEG_0:   begin src_r = r;   src_c = cm; end
      DEG_90:  begin src_r = ~cm; src_c = r;  end
      DEG_180: begin src_r = ~r;  src_c = ~cm; end
      DEG_270: begin src_r = cm;  src_c = ~r; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rot_tile_addr_gen.sv
// Two-stage read/write address generator for rotating one square tile:
// stage 1 issues source reads, stage 2 issues the aligned destination writes.
module rot_tile_addr_gen
  import rot_pkg::*;
#(
  parameter int TILE     = 8,
  parameter int CHANNELS = 3
) (
  input  logic                                           I_RA_HCLK,
  input  logic                                           I_RA_RESET,
  input  logic                                           I_RA_START,
  input  logic                                           I_RA_ABORT,
  input  logic [1:0]                                     I_RA_DEGREES,
  input  logic                                           I_RA_DIRECTION,
  input  logic                                           I_RA_MIRROR,
  input  logic [$clog2(TILE):0]                          I_RA_VALID_W,
  input  logic [$clog2(TILE):0]                          I_RA_VALID_H,
  input  logic                                           I_RA_STALL,
  output logic                                           O_RA_RD_EN,
  output logic [CHANNELS*$clog2(TILE*TILE*CHANNELS)-1:0] O_RA_SRC_ADDR,
  output logic                                           O_RA_WR_EN,
  output logic [CHANNELS*$clog2(TILE*TILE*CHANNELS)-1:0] O_RA_DST_ADDR,
  output logic                                           O_RA_PAD,
  output logic                                           O_RA_BUSY,
  output logic                                           O_RA_DONE
);

  localparam int CNT_W  = $clog2(TILE);
  localparam int ADDR_W = $clog2(TILE*TILE*CHANNELS);
  localparam int VEC_W  = CHANNELS*ADDR_W;
  localparam logic [CNT_W:0] TILE_V = (CNT_W+1)'(TILE);

  state_e             state_q, state_d;
  logic [1:0]         deg_q, deg_d;
  logic               mir_q, mir_d;
  logic [CNT_W:0]     vw_q, vw_d, vh_q, vh_d;
  logic [CNT_W-1:0]   row_q, row_d, col_q, col_d;
  logic               v1_q, v1_d, rd_q, rd_d, pad1_q, pad1_d;
  logic [VEC_W-1:0]   src_q, src_d, dst1_q, dst1_d, dst_q, dst_d;
  logic               wr_q, wr_d, pad_q, pad_d, busy_q, busy_d, done_q, done_d;

  logic               idle, issue, adv, last, pix_pad;
  logic [1:0]         in_deg, cur_deg;
  logic               cur_mir;
  logic [CNT_W:0]     in_vw, in_vh, cur_vw, cur_vh;
  logic [CNT_W-1:0]   src_r, src_c;
  logic [VEC_W-1:0]   src_w, dst_w;

  // While idle the mapper sees the live inputs so pixel 0 issues on the start edge.
  assign idle    = (state_q == IDLE);
  assign in_deg  = eff_deg(I_RA_DEGREES, I_RA_DIRECTION);
  assign in_vw   = (I_RA_VALID_W == '0 || I_RA_VALID_W > TILE_V) ? TILE_V : I_RA_VALID_W;
  assign in_vh   = (I_RA_VALID_H == '0 || I_RA_VALID_H > TILE_V) ? TILE_V : I_RA_VALID_H;
  assign cur_deg = idle ? in_deg      : deg_q;
  assign cur_mir = idle ? I_RA_MIRROR : mir_q;
  assign cur_vw  = idle ? in_vw       : vw_q;
  assign cur_vh  = idle ? in_vh       : vh_q;
  assign last    = (row_q == '1) && (col_q == '1);

  rot_coord_map #(.TILE(TILE), .CNT_W(CNT_W)) u_map (
    .r(row_q), .c(col_q), .deg_cw(cur_deg), .mirror(cur_mir),
    .src_r(src_r), .src_c(src_c)
  );

  assign pix_pad = ({1'b0, src_c} >= cur_vw) || ({1'b0, src_r} >= cur_vh);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign src_w[k*ADDR_W +: ADDR_W] = ADDR_W'({src_r, src_c}) * ADDR_W'(CHANNELS) + ADDR_W'(k);
    assign dst_w[k*ADDR_W +: ADDR_W] = ADDR_W'({row_q, col_q}) * ADDR_W'(CHANNELS) + ADDR_W'(k);
  end

  always_comb begin
    state_d = state_q; deg_d = deg_q; mir_d = mir_q; vw_d = vw_q; vh_d = vh_q;
    row_d = row_q; col_d = col_q;
    v1_d = v1_q; rd_d = rd_q; pad1_d = pad1_q; src_d = src_q; dst1_d = dst1_q;
    wr_d = wr_q; pad_d = pad_q; dst_d = dst_q; busy_d = busy_q; done_d = done_q;
    issue = 1'b0;
    adv   = 1'b0;
    case (state_q)
      IDLE: if (I_RA_START) begin
        state_d = RUN; deg_d = in_deg; mir_d = I_RA_MIRROR; vw_d = in_vw; vh_d = in_vh;
        busy_d = 1'b1; issue = 1'b1; adv = 1'b1;
      end
      RUN: if (!I_RA_STALL) begin
        issue = 1'b1; adv = 1'b1;
        if (last) state_d = FLUSH;
      end
      FLUSH: if (!I_RA_STALL) begin
        adv = 1'b1;
        if (wr_q && !v1_q) begin state_d = DONE; done_d = 1'b1; end
      end
      DONE: begin state_d = IDLE; done_d = 1'b0; busy_d = 1'b0; end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      v1_d   = issue;
      rd_d   = issue & ~pix_pad;
      pad1_d = issue & pix_pad;
      if (issue) begin src_d = src_w; dst1_d = dst_w; end
      wr_d  = v1_q;
      pad_d = pad1_q;
      if (v1_q) dst_d = dst1_q;
    end
    if (issue) begin
      col_d = col_q + 1'b1;
      if (col_q == '1) row_d = row_q + 1'b1;
    end
    if (I_RA_ABORT) begin
      state_d = IDLE; row_d = '0; col_d = '0;
      v1_d = 1'b0; rd_d = 1'b0; pad1_d = 1'b0; wr_d = 1'b0; pad_d = 1'b0;
      busy_d = 1'b0; done_d = 1'b0;
    end
  end

  always_ff @(posedge I_RA_HCLK or posedge I_RA_RESET) begin
    if (I_RA_RESET) begin
      state_q <= IDLE; deg_q <= '0; mir_q <= 1'b0; vw_q <= '0; vh_q <= '0;
      row_q <= '0; col_q <= '0;
      v1_q <= 1'b0; rd_q <= 1'b0; pad1_q <= 1'b0; src_q <= '0; dst1_q <= '0;
      wr_q <= 1'b0; pad_q <= 1'b0; dst_q <= '0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; deg_q <= deg_d; mir_q <= mir_d; vw_q <= vw_d; vh_q <= vh_d;
      row_q <= row_d; col_q <= col_d;
      v1_q <= v1_d; rd_q <= rd_d; pad1_q <= pad1_d; src_q <= src_d; dst1_q <= dst1_d;
      wr_q <= wr_d; pad_q <= pad_d; dst_q <= dst_d; busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign O_RA_RD_EN    = rd_q & ~I_RA_STALL;
  assign O_RA_WR_EN    = wr_q & ~I_RA_STALL;
  assign O_RA_SRC_ADDR = src_q;
  assign O_RA_DST_ADDR = dst_q;
  assign O_RA_PAD      = pad_q;
  assign O_RA_BUSY     = busy_q;
  assign O_RA_DONE     = done_q;

endmodule

// File: tb/tb_rot_tile_addr_gen.sv
// Bench for rot_tile_addr_gen: an image-transform model predicts the read
// and write streams for directed and random tiles.
module tb_rot_tile_addr_gen;

  localparam int T   = 8;
  localparam int CH  = 3;
  localparam int CW  = $clog2(T);
  localparam int AW  = $clog2(T*T*CH);
  localparam int N   = T*T;

  logic              clk = 1'b0, rst = 1'b1;
  logic              start = 1'b0, abort = 1'b0, mirror = 1'b0, dir = 1'b0, stall = 1'b0;
  logic [1:0]        degrees = '0;
  logic [CW:0]       vw = '0, vh = '0;
  logic              rd_en, wr_en, pad, busy, done;
  logic [CH*AW-1:0]  src, dst;

  int n_assert = 0, n_fail = 0;
  int exp_src[N];
  bit exp_pad[N];

  always #5 clk = ~clk;

  rot_tile_addr_gen #(.TILE(T), .CHANNELS(CH)) dut (
    .I_RA_HCLK(clk), .I_RA_RESET(rst), .I_RA_START(start), .I_RA_ABORT(abort),
    .I_RA_DEGREES(degrees), .I_RA_DIRECTION(dir), .I_RA_MIRROR(mirror),
    .I_RA_VALID_W(vw), .I_RA_VALID_H(vh), .I_RA_STALL(stall),
    .O_RA_RD_EN(rd_en), .O_RA_SRC_ADDR(src), .O_RA_WR_EN(wr_en), .O_RA_DST_ADDR(dst),
    .O_RA_PAD(pad), .O_RA_BUSY(busy), .O_RA_DONE(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*AW-1:0] pack(input int idx);
    logic [CH*AW-1:0] v;
    for (int k = 0; k < CH; k++) v[k*AW +: AW] = AW'(idx*CH + k);
    return v;
  endfunction

  // Rotate a labelled image one quarter-turn at a time, then mirror it.
  function automatic void build(input int deg, input int d, input int mir, input int w, input int h);
    int img[T][T];
    int tmp[T][T];
    int ew, eh, s;
    for (int r = 0; r < T; r++) for (int c = 0; c < T; c++) img[r][c] = r*T + c;
    for (int i = 0; i < deg; i++) begin
      for (int r = 0; r < T; r++)
        for (int c = 0; c < T; c++)
          tmp[r][c] = (d == 0) ? img[T-1-c][r] : img[c][T-1-r];
      img = tmp;
    end
    ew = (w == 0 || w > T) ? T : w;
    eh = (h == 0 || h > T) ? T : h;
    for (int n = 0; n < N; n++) begin
      s = mir ? img[n/T][T-1-(n%T)] : img[n/T][n%T];
      exp_src[n] = s;
      exp_pad[n] = ((s % T) >= ew) || ((s / T) >= eh);
    end
  endfunction

  task automatic run_tile(input int deg, input int d, input int mir, input int w, input int h,
                          input int st_at, input int abort_at, input bit rnd_stall);
    int wr_cnt = 0, rd_cnt = 0, pad_cnt = 0, exp_pad_cnt = 0, exp_rd = 0;
    int last_wr = -1, first_wr = -1, cyc = 0;
    int rdq[$];
    bit done_seen = 0, aborted = 0, st;
    build(deg, d, mir, w, h);
    for (int n = 0; n < N; n++) if (exp_pad[n]) exp_pad_cnt++; else rdq.push_back(exp_src[n]);
    exp_rd = rdq.size();
    @(negedge clk);
    start = 1'b1; degrees = 2'(deg); dir = d[0]; mirror = mir[0];
    vw = (CW+1)'(w); vh = (CW+1)'(h); stall = 1'b0; abort = 1'b0;
    #1 chk("busy_before_start", busy, 0);
    while (!done_seen && !aborted && cyc < 3000) begin
      cyc++;
      @(negedge clk);
      start   = (cyc == 9);
      degrees = 2'($urandom); dir = 1'($urandom); mirror = 1'($urandom);
      vw = (CW+1)'($urandom); vh = (CW+1)'($urandom);
      st = (st_at > 0 && cyc >= st_at && cyc < st_at + 4) || (rnd_stall && $urandom_range(0, 3) == 0);
      stall = st;
      #1;
      chk("busy_run", busy, 1);
      if (st) begin chk("rd_in_stall", rd_en, 0); chk("wr_in_stall", wr_en, 0); end
      if (rd_en) begin
        if (rdq.size() == 0) chk("rd_extra", 1, 0);
        else chk("src_addr", src, pack(rdq.pop_front()));
        rd_cnt++;
      end
      if (wr_en) begin
        if (wr_cnt >= N) chk("wr_extra", 1, 0);
        else begin
          chk("dst_addr", dst, pack(wr_cnt));
          chk("pad_flag", pad, exp_pad[wr_cnt]);
        end
        if (pad) pad_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
      end
      if (done) begin
        done_seen = 1;
        chk("done_latency", cyc - last_wr, 1);
      end
      if (abort_at >= 0 && wr_cnt == abort_at) aborted = 1;
    end
    if (aborted) begin
      @(negedge clk); abort = 1'b1; start = 1'b1; stall = 1'b0;
      @(negedge clk); abort = 1'b0; start = 1'b0;
      #1;
      chk("abort_rd", rd_en, 0); chk("abort_wr", wr_en, 0); chk("abort_busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk); #1;
        chk("abort_no_done", done, 0);
      end
    end else begin
      chk("timeout_done_seen", done_seen, 1);
      chk("wr_count", wr_cnt, N);
      chk("rd_count", rd_cnt, exp_rd);
      chk("pad_count", pad_cnt, exp_pad_cnt);
      if (!rnd_stall && (st_at == 0 || st_at > 2)) chk("first_wr_cycle", first_wr, 2);
      @(negedge clk); stall = 1'b0; #1;
      chk("busy_after_done", busy, 0);
      chk("done_single", done, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd", rd_en, 0); chk("rst_wr", wr_en, 0); chk("rst_pad", pad, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_src", src, 0); chk("rst_dst", dst, 0);
    @(negedge clk); rst = 1'b0;

    run_tile(0, 0, 0, 8, 8, 0, -1, 0);   // straight copy
    run_tile(1, 0, 0, 8, 8, 0, -1, 0);   // CW90
    run_tile(3, 1, 0, 8, 8, 0, -1, 0);   // CCW270 == CW90
    run_tile(2, 0, 1, 8, 8, 0, -1, 0);   // 180 + mirror
    run_tile(0, 0, 0, 5, 3, 0, -1, 0);   // partial edge tile
    run_tile(0, 0, 0, 8, 8, 12, -1, 0);  // 4-cycle stall mid-row
    run_tile(0, 0, 0, 8, 8, 0, 20, 0);   // abort at write 20
    run_tile(0, 0, 0, 8, 8, 0, -1, 0);   // restart after abort
    run_tile(1, 1, 1, 0, 12, 0, -1, 1);  // out-of-range valid sizes
    for (int i = 0; i < 5; i++)
      run_tile($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 15), $urandom_range(0, 15), 0, -1, 1);

    // Asynchronous reset in the middle of a tile.
    @(negedge clk); start = 1'b1; degrees = 2'd0; dir = 1'b0; mirror = 1'b0; vw = 4'd8; vh = 4'd8;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_rd", rd_en, 0); chk("midrst_wr", wr_en, 0); chk("midrst_busy", busy, 0);
    chk("midrst_dst", dst, 0); chk("midrst_src", src, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("post_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
